// File: rtl/dbg_pkg.sv
// Shared encodings for the debug access unit: address spaces, FSM states,
// control register layout and the latched request header.
package dbg_pkg;

   localparam int unsigned HART_W    = 2;
   localparam int unsigned SPACE_W   = 2;
   localparam int unsigned ADDR_W    = 12;
   localparam int unsigned GPR_IDX_W = 5;

   typedef enum logic [SPACE_W-1:0] {
      SPACE_GPR  = 2'd0,
      SPACE_CSR  = 2'd1,
      SPACE_CTRL = 2'd2,
      SPACE_RSVD = 2'd3
   } dbg_space_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } dau_state_e;

   // Only one control register exists, at offset 0
   localparam logic [ADDR_W-1:0] CTRL_OFFSET = 12'h000;

   // Control write data bits
   localparam int unsigned CTRL_HALT_BIT   = 0;
   localparam int unsigned CTRL_RESUME_BIT = 1;

   // Request header captured at acceptance and presented on the core port
   typedef struct packed {
      logic              we;
      logic [HART_W-1:0] hart;
      dbg_space_e        space;
      logic [ADDR_W-1:0] addr;
   } dbg_req_t;

endpackage

// File: rtl/debug_access_unit_if.sv
// Host-side request/response handshake of the debug access unit.
interface debug_access_unit_if #(
   parameter int unsigned XLEN = 32
);
   import dbg_pkg::*;

   logic                dbg_valid;
   logic                dbg_ready;
   logic                dbg_write;
   logic [HART_W-1:0]   dbg_hart;
   logic [SPACE_W-1:0]  dbg_space;
   logic [ADDR_W-1:0]   dbg_addr;
   logic [XLEN-1:0]     dbg_wdata;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [XLEN-1:0]     rsp_data;
   logic                rsp_err;

   // Debug host side
   modport master (
      output dbg_valid, dbg_write, dbg_hart, dbg_space, dbg_addr, dbg_wdata, rsp_ready,
      input  dbg_ready, rsp_valid, rsp_data, rsp_err
   );

   // Debug access unit side
   modport slave (
      input  dbg_valid, dbg_write, dbg_hart, dbg_space, dbg_addr, dbg_wdata, rsp_ready,
      output dbg_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/debug_access_unit.sv
// Debug access unit: accepts host requests, checks legality, forwards GPR/CSR
// accesses to a halted core with a timeout, and owns per-hart halt/resume control.
module debug_access_unit
   import dbg_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NUM_HARTS = 2,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   debug_access_unit_if.slave   bus,
   output logic [NUM_HARTS-1:0] halt_req,
   output logic [NUM_HARTS-1:0] resume_req,
   input  logic [NUM_HARTS-1:0] halted,
   output logic                 core_req,
   output logic                 core_we,
   output logic [HART_W-1:0]    core_hart,
   output logic [SPACE_W-1:0]   core_space,
   output logic [ADDR_W-1:0]    core_addr,
   output logic [XLEN-1:0]      core_wdata,
   input  logic                 core_ack,
   input  logic [XLEN-1:0]      core_rdata
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   dau_state_e           state_q, state_d;
   dbg_req_t             req_q, req_d;
   logic [XLEN-1:0]      wdata_q, wdata_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 core_req_q, core_req_d;
   logic                 dbg_ready_q, dbg_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [XLEN-1:0]      rsp_data_q, rsp_data_d;
   logic [NUM_HARTS-1:0] halt_req_q, halt_req_d;
   logic [NUM_HARTS-1:0] resume_req_q, resume_req_d;

   dbg_space_e           space_c;
   logic [NUM_HARTS-1:0] hart_sel_c;
   logic                 hart_ok_c;
   logic                 sel_halted_c;
   logic                 sel_halt_req_c;
   logic                 illegal_c;

   // Decode the incoming request: one-hot hart select and legality
   always_comb begin
      space_c    = dbg_space_e'(bus.dbg_space);
      hart_sel_c = '0;
      hart_ok_c  = 1'b0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
         if (bus.dbg_hart == HART_W'(h)) begin
            hart_sel_c[h] = 1'b1;
            hart_ok_c     = 1'b1;
         end
      end
      sel_halted_c   = |(hart_sel_c & halted);
      sel_halt_req_c = |(hart_sel_c & halt_req_q);
      illegal_c = !hart_ok_c
               || (space_c == SPACE_RSVD)
               || (((space_c == SPACE_GPR) || (space_c == SPACE_CSR)) && !sel_halted_c)
               || ((space_c == SPACE_CTRL) && (bus.dbg_addr != CTRL_OFFSET));
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      core_req_d   = core_req_q;
      dbg_ready_d  = dbg_ready_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_err_d    = rsp_err_q;
      rsp_data_d   = rsp_data_q;
      halt_req_d   = halt_req_q;
      resume_req_d = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.dbg_valid) begin
               req_d       = '{we: bus.dbg_write, hart: bus.dbg_hart,
                               space: space_c, addr: bus.dbg_addr};
               wdata_d     = bus.dbg_wdata;
               cnt_d       = '0;
               dbg_ready_d = 1'b0;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b0;
               if (illegal_c) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (space_c == SPACE_CTRL) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  if (bus.dbg_write) begin
                     // Resume takes priority when both bits are set
                     if (bus.dbg_wdata[CTRL_RESUME_BIT]) begin
                        halt_req_d   = halt_req_q & ~hart_sel_c;
                        resume_req_d = hart_sel_c;
                     end else if (bus.dbg_wdata[CTRL_HALT_BIT]) begin
                        halt_req_d   = halt_req_q | hart_sel_c;
                     end
                  end else begin
                     rsp_data_d = XLEN'({sel_halt_req_c, sel_halted_c});
                  end
               end else if ((space_c == SPACE_GPR) && bus.dbg_write
                            && (bus.dbg_addr[GPR_IDX_W-1:0] == '0)) begin
                  // x0 is hard-wired, nothing to write
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
               end else begin
                  state_d    = ST_ACCESS;
                  core_req_d = 1'b1;
               end
            end
         end

         ST_ACCESS: begin
            if (core_ack) begin
               state_d     = ST_RESP;
               core_req_d  = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = req_q.we ? '0 : core_rdata;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = ST_RESP;
               core_req_d  = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_data_d  = '0;
               dbg_ready_d = 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            core_req_d  = 1'b0;
            rsp_valid_d = 1'b0;
            dbg_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         core_req_q   <= 1'b0;
         dbg_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_data_q   <= '0;
         halt_req_q   <= '0;
         resume_req_q <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         core_req_q   <= core_req_d;
         dbg_ready_q  <= dbg_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_data_q   <= rsp_data_d;
         halt_req_q   <= halt_req_d;
         resume_req_q <= resume_req_d;
      end
   end

   assign bus.dbg_ready = dbg_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_data  = rsp_data_q;
   assign halt_req      = halt_req_q;
   assign resume_req    = resume_req_q;
   assign core_req      = core_req_q;
   assign core_we       = req_q.we;
   assign core_hart     = req_q.hart;
   assign core_space    = req_q.space;
   assign core_addr     = req_q.addr;
   assign core_wdata    = wdata_q;

endmodule

// File: tb/tb_debug_access_unit.sv
// Scoreboard bench for debug_access_unit: expected responses are queued when a
// request is driven and compared when rsp_valid appears.
module tb_debug_access_unit;
   import dbg_pkg::*;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned NUM_HARTS = 2;
   localparam int unsigned TIMEOUT   = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_HARTS-1:0] halt_req, resume_req, halted;
   logic                 core_req, core_we, core_ack;
   logic [HART_W-1:0]    core_hart;
   logic [SPACE_W-1:0]   core_space;
   logic [ADDR_W-1:0]    core_addr;
   logic [XLEN-1:0]      core_wdata, core_rdata;

   debug_access_unit_if #(.XLEN(XLEN)) bus ();

   debug_access_unit #(.XLEN(XLEN), .NUM_HARTS(NUM_HARTS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .halt_req(halt_req), .resume_req(resume_req), .halted(halted),
      .core_req(core_req), .core_we(core_we), .core_hart(core_hart),
      .core_space(core_space), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_ack(core_ack), .core_rdata(core_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0] data;
      logic            err;
      int              lat;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   t_acc   = 0;
   int   core_req_cycles = 0;
   int   resume_cycles   = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_req === 1'b1) core_req_cycles <= core_req_cycles + 1;
      if (resume_req !== '0) resume_cycles <= resume_cycles + 1;
   end

   // Present one request, queue its expected response; returns in cycle T+1
   task automatic send(input logic we, input logic [1:0] hart, input logic [1:0] space,
                       input logic [11:0] addr, input logic [XLEN-1:0] wdata,
                       input logic [XLEN-1:0] exp_data, input logic exp_err, input int exp_lat);
      exp_t e;
      @(negedge clk);
      vectors++;
      if (bus.dbg_ready !== 1'b1) begin
         errors++;
         $display("FAIL dbg_ready_before_accept: got %b want 1", bus.dbg_ready);
      end
      bus.dbg_write = we;
      bus.dbg_hart  = hart;
      bus.dbg_space = space;
      bus.dbg_addr  = addr;
      bus.dbg_wdata = wdata;
      bus.dbg_valid = 1'b1;
      e.data = exp_data;
      e.err  = exp_err;
      e.lat  = exp_lat;
      sb.push_back(e);
      @(negedge clk);
      bus.dbg_valid = 1'b0;
      t_acc = cyc;
   endtask

   // Wait for the response, compare it to the scoreboard head, then drain it
   task automatic collect_rsp(input string name);
      exp_t e;
      int   waited = 0;
      while (bus.rsp_valid !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: response with no queued expectation", name);
         return;
      end
      e = sb.pop_front();
      if (bus.rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s rsp_valid: got %b want 1 within 40 cycles", name, bus.rsp_valid);
         return;
      end
      vectors++;
      if (bus.rsp_data !== e.data) begin
         errors++;
         $display("FAIL %s rsp_data: got %h want %h", name, bus.rsp_data, e.data);
      end
      vectors++;
      if (bus.rsp_err !== e.err) begin
         errors++;
         $display("FAIL %s rsp_err: got %b want %b", name, bus.rsp_err, e.err);
      end
      vectors++;
      if (cyc - t_acc + 1 != e.lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, cyc - t_acc + 1, e.lat);
      end
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.data || bus.rsp_err !== e.err) begin
         errors++;
         $display("FAIL %s rsp_hold: got v=%b d=%h e=%b want v=1 d=%h e=%b", name,
                  bus.rsp_valid, bus.rsp_data, bus.rsp_err, e.data, e.err);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.dbg_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s rsp_release: got v=%b rdy=%b want v=0 rdy=1", name,
                  bus.rsp_valid, bus.dbg_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (bus.dbg_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake: got rdy=%b v=%b e=%b want 1 0 0",
                  bus.dbg_ready, bus.rsp_valid, bus.rsp_err);
      end
      vectors++;
      if (bus.rsp_data !== '0 || halt_req !== '0 || resume_req !== '0) begin
         errors++;
         $display("FAIL reset_data: got d=%h h=%b r=%b want 0", bus.rsp_data, halt_req, resume_req);
      end
      vectors++;
      if (core_req !== 1'b0 || core_we !== 1'b0 || core_hart !== '0 || core_space !== '0
          || core_addr !== '0 || core_wdata !== '0) begin
         errors++;
         $display("FAIL reset_core: got req=%b we=%b hart=%h sp=%h a=%h wd=%h want all 0",
                  core_req, core_we, core_hart, core_space, core_addr, core_wdata);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_gpr_read();
      send(1'b0, 2'd0, SPACE_GPR, 12'h001, '0, 32'h1, 1'b0, 4);
      vectors++;
      if (core_req !== 1'b1 || core_we !== 1'b0 || core_hart !== 2'd0
          || core_space !== 2'(SPACE_GPR) || core_addr !== 12'h001) begin
         errors++;
         $display("FAIL gpr_read_core_port: got req=%b we=%b hart=%h sp=%h a=%h want 1 0 0 0 001",
                  core_req, core_we, core_hart, core_space, core_addr);
      end
      @(negedge clk);
      @(negedge clk);
      core_ack   = 1'b1;
      core_rdata = 32'h1;
      @(negedge clk);
      core_ack   = 1'b0;
      core_rdata = '0;
      collect_rsp("gpr_read");
   endtask

   task automatic test_csr_not_halted();
      int c0 = core_req_cycles;
      send(1'b0, 2'd1, SPACE_CSR, 12'h801, '0, '0, 1'b1, 1);
      collect_rsp("csr_not_halted");
      vectors++;
      if (core_req_cycles - c0 != 0) begin
         errors++;
         $display("FAIL csr_not_halted_core_req: got %0d cycles want 0", core_req_cycles - c0);
      end
   endtask

   task automatic test_control();
      int r0;
      send(1'b1, 2'd0, SPACE_CTRL, CTRL_OFFSET, 32'h1, '0, 1'b0, 1);
      vectors++;
      if (halt_req !== 2'b01 || resume_req !== 2'b00) begin
         errors++;
         $display("FAIL ctrl_halt: got h=%b r=%b want 01 00", halt_req, resume_req);
      end
      collect_rsp("ctrl_halt");
      send(1'b0, 2'd0, SPACE_CTRL, CTRL_OFFSET, '0, 32'h3, 1'b0, 1);
      collect_rsp("ctrl_read_halting");
      r0 = resume_cycles;
      send(1'b1, 2'd0, SPACE_CTRL, CTRL_OFFSET, 32'h2, '0, 1'b0, 1);
      vectors++;
      if (halt_req !== 2'b00 || resume_req !== 2'b01) begin
         errors++;
         $display("FAIL ctrl_resume: got h=%b r=%b want 00 01", halt_req, resume_req);
      end
      collect_rsp("ctrl_resume");
      vectors++;
      if (resume_cycles - r0 != 1 || resume_req !== 2'b00) begin
         errors++;
         $display("FAIL ctrl_resume_pulse: got %0d cycles want 1", resume_cycles - r0);
      end
      send(1'b0, 2'd0, SPACE_CTRL, CTRL_OFFSET, '0, 32'h1, 1'b0, 1);
      collect_rsp("ctrl_read_resumed");
      send(1'b1, 2'd1, SPACE_CTRL, CTRL_OFFSET, 32'h1, '0, 1'b0, 1);
      collect_rsp("ctrl_halt_h1");
      send(1'b1, 2'd1, SPACE_CTRL, CTRL_OFFSET, 32'h3, '0, 1'b0, 1);
      vectors++;
      if (halt_req !== 2'b00 || resume_req !== 2'b10) begin
         errors++;
         $display("FAIL ctrl_both_bits: got h=%b r=%b want 00 10", halt_req, resume_req);
      end
      collect_rsp("ctrl_both_bits");
   endtask

   task automatic test_illegal();
      int c0 = core_req_cycles;
      send(1'b0, 2'd2, SPACE_GPR,  12'h001, '0, '0, 1'b1, 1);
      collect_rsp("bad_hart");
      send(1'b0, 2'd0, SPACE_RSVD, 12'h000, '0, '0, 1'b1, 1);
      collect_rsp("rsvd_space");
      send(1'b1, 2'd0, SPACE_CTRL, 12'h004, 32'h1, '0, 1'b1, 1);
      collect_rsp("bad_ctrl_offset");
      send(1'b1, 2'd1, SPACE_GPR,  12'h003, 32'h9, '0, 1'b1, 1);
      collect_rsp("gpr_not_halted");
      send(1'b1, 2'd0, SPACE_GPR,  12'h000, 32'hFFFF_FFFF, '0, 1'b0, 1);
      collect_rsp("gpr_x0_write");
      vectors++;
      if (core_req_cycles - c0 != 0 || halt_req !== 2'b00) begin
         errors++;
         $display("FAIL illegal_side_effects: got core_req %0d cycles h=%b want 0 00",
                  core_req_cycles - c0, halt_req);
      end
   endtask

   task automatic test_timeout();
      int c0 = core_req_cycles;
      send(1'b1, 2'd0, SPACE_GPR, 12'h002, 32'h1234_5678, '0, 1'b1, TIMEOUT + 1);
      vectors++;
      if (core_we !== 1'b1 || core_wdata !== 32'h1234_5678 || core_addr !== 12'h002) begin
         errors++;
         $display("FAIL timeout_core_port: got we=%b wd=%h a=%h want 1 12345678 002",
                  core_we, core_wdata, core_addr);
      end
      collect_rsp("timeout");
      vectors++;
      if (core_req_cycles - c0 != int'(TIMEOUT)) begin
         errors++;
         $display("FAIL timeout_core_req_len: got %0d want %0d", core_req_cycles - c0, TIMEOUT);
      end
   endtask

   task automatic test_back_to_back();
      // Stray acks while idle must not disturb anything
      core_ack   = 1'b1;
      core_rdata = 32'hFFFF_0000;
      repeat (2) @(negedge clk);
      core_ack   = 1'b0;
      core_rdata = '0;
      send(1'b0, 2'd0, SPACE_GPR, 12'h005, '0, 32'hDEAD_BEEF, 1'b0, 2);
      halted     = 2'b00;
      core_ack   = 1'b1;
      core_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      core_ack   = 1'b0;
      core_rdata = '0;
      collect_rsp("halted_drop_mid_access");
      send(1'b0, 2'd0, SPACE_CSR, 12'h300, '0, '0, 1'b1, 1);
      collect_rsp("csr_after_halt_drop");
      halted = 2'b01;
      send(1'b1, 2'd0, SPACE_CSR, 12'h300, 32'hA5, '0, 1'b0, 3);
      vectors++;
      if (core_space !== 2'(SPACE_CSR) || core_addr !== 12'h300 || core_we !== 1'b1) begin
         errors++;
         $display("FAIL csr_write_port: got sp=%h a=%h we=%b want 1 300 1",
                  core_space, core_addr, core_we);
      end
      @(negedge clk);
      core_ack   = 1'b1;
      core_rdata = 32'h5555_5555;
      @(negedge clk);
      core_ack   = 1'b0;
      core_rdata = '0;
      collect_rsp("csr_write");
   endtask

   task automatic test_reset_mid();
      int c0;
      int seen = 0;
      send(1'b0, 2'd0, SPACE_GPR, 12'h007, '0, '0, 1'b0, 1);
      void'(sb.pop_back());
      vectors++;
      if (core_req !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_in_access: got core_req=%b want 1", core_req);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if (core_req !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.dbg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_async: got req=%b v=%b rdy=%b want 0 0 1",
                  core_req, bus.rsp_valid, bus.dbg_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0) seen++;
      end
      vectors++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid_no_rsp: got %0d valid cycles want 0", seen);
      end
      c0 = core_req_cycles;
      send(1'b1, 2'd0, SPACE_GPR, 12'h000, 32'h55, '0, 1'b0, 1);
      collect_rsp("x0_after_reset");
      vectors++;
      if (core_req_cycles - c0 != 0) begin
         errors++;
         $display("FAIL x0_after_reset_core_req: got %0d want 0", core_req_cycles - c0);
      end
   endtask

   initial begin
      reset         = 1'b0;
      bus.dbg_valid = 1'b0;
      bus.dbg_write = 1'b0;
      bus.dbg_hart  = '0;
      bus.dbg_space = '0;
      bus.dbg_addr  = '0;
      bus.dbg_wdata = '0;
      bus.rsp_ready = 1'b0;
      core_ack      = 1'b0;
      core_rdata    = '0;
      halted        = 2'b01;

      test_reset();
      test_gpr_read();
      test_csr_not_halted();
      test_control();
      test_illegal();
      test_timeout();
      test_back_to_back();
      test_reset_mid();

      vectors++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/debug_access_unit.md
DEBUG_ACCESS_UNIT -- requirements
Module: debug_access_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NUM_HARTS, default 2, range 1..4, harts served.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles waiting for core_ack.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 dbg_valid/dbg_ready  in/out  1/1  host request handshake.
REQ-007 dbg_write  in  1  1=write, 0=read.
REQ-008 dbg_hart  in  2  target hart index.
REQ-009 dbg_space  in  2  0=GPR, 1=CSR, 2=control, 3=reserved.
REQ-010 dbg_addr  in  12  GPR index (bits 4:0), CSR number, or control offset.
REQ-011 dbg_wdata  in  XLEN  write data.
REQ-012 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-013 rsp_data  out  XLEN  read data; 0 on writes and errors.
REQ-014 rsp_err  out  1  access failed.
REQ-015 halt_req  out  NUM_HARTS  per-hart level halt request.
REQ-016 resume_req  out  NUM_HARTS  per-hart one-cycle resume pulse.
REQ-017 halted  in  NUM_HARTS  per-hart halted status from core.
REQ-018 core_req, core_we, core_hart[1:0], core_space, core_addr[11:0], core_wdata[XLEN]  out  core access port.
REQ-019 core_ack  in  1 and core_rdata  in  XLEN  core access completion.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, RESP; dbg_ready=1 only in IDLE.
REQ-021 IDLE: on dbg_valid, SHALL latch request and go to ACCESS if legal, else straight to RESP with rsp_err=1.
REQ-022 Illegal: dbg_hart>=NUM_HARTS; dbg_space=3; GPR/CSR access to a hart whose halted bit is 0; control offset other than 0.
REQ-023 GPR write to index 0 SHALL skip the core access, go to RESP, rsp_err=0.
REQ-024 ACCESS: core_req=1 with latched fields stable until the cycle core_ack=1; core_rdata captured that cycle; then RESP.
REQ-025 ACCESS SHALL count cycles; if core_ack is still 0 after TIMEOUT cycles, core_req drops, then RESP with rsp_err=1 and rsp_data=0.
REQ-026 Control write (space 2, offset 0): bit0=1 sets halt_req[hart]; bit1=1 clears halt_req[hart] and pulses resume_req[hart] one cycle; both set: resume wins; no core access; then RESP.
REQ-027 Control read: rsp_data={..0, halt_req[hart], halted[hart]}.
REQ-028 RESP: rsp_valid=1, outputs held until rsp_ready=1, then IDLE next cycle.
REQ-029 Latency: accept at cycle T, core_req from T+1; ack at cycle A gives rsp_valid at A+1; illegal/control requests give rsp_valid at T+1.
REQ-030 core_ack outside ACCESS SHALL be ignored.
REQ-031 halted input SHALL be sampled only at acceptance; a later de-assertion does not abort ACCESS.

Reset
REQ-032 Reset assertion SHALL force IDLE immediately, mid-transaction included, with no response for the lost request.
REQ-033 Reset values: dbg_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, halt_req=0, resume_req=0, core_req=0, core_we=0, all core_* fields=0, timeout counter=0.

Structure
REQ-034 Shared package dbg_pkg SHALL hold the space encodings, FSM state enum, control offset 0, and halt/resume bit positions.
REQ-035 Single module; the timeout counter is inline, no sub-module.

Verification
REQ-036 Hart0 halted=1, GPR read addr 1, core_ack after 3 cycles with rdata 0x1 -> rsp_data=0x1, err=0, rsp_valid 4 cycles after accept.
REQ-037 Hart1 halted=0, CSR read 0x801 -> core_req never asserted, rsp_err=1 at T+1.
REQ-038 Control write hart0 data 0x1 then 0x2 -> halt_req[0]=1, then halt_req[0]=0 with resume_req[0] pulsing exactly one cycle.
REQ-039 GPR write 0x12345678 to addr 2, core_ack withheld -> core_req drops after 16 cycles, rsp_err=1, rsp_data=0.
REQ-040 reset low during ACCESS with rsp_ready=0 -> core_req=0, rsp_valid=0, dbg_ready=1 immediately; GPR write addr 0 -> no core_req, err=0.
